// File: rtl/ex_div_ctrl.sv
// ============================================================================
// Module   : ex_div_ctrl
// Summary  : Multi-cycle 32-bit signed/unsigned restoring divider for the EX
//            stage. Optional early-out path enabled by macro DIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);

   localparam logic [5:0] C_LAST_ITER = 6'd32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_BYZERO = 2'b01,
      S_ON     = 2'b10,
      S_END    = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] work_q, work_d;
   logic [31:0] divisor_q, divisor_d;
   logic        signed_q, signed_d;
   logic        a_sign_q, a_sign_d;
   logic        b_sign_q, b_sign_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic        a_neg, b_neg;
   logic [31:0] abs_dividend, abs_divisor;
   logic        step_ge;
   logic [31:0] step_diff;
   logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

   // Magnitudes of incoming operands; 0x80000000 negates to itself, which is
   // exactly 2^31 when read as unsigned.
   assign a_neg        = signed_div_i & opdata1_i[31];
   assign b_neg        = signed_div_i & opdata2_i[31];
   assign abs_dividend = a_neg ? (~opdata1_i + 32'd1) : opdata1_i;
   assign abs_divisor  = b_neg ? (~opdata2_i + 32'd1) : opdata2_i;

   // work_q layout: [64:33] partial remainder, [32:1] dividend/quotient bits,
   // [0] next quotient bit. The trial compare uses 33 bits so divisors with
   // bit 31 set are handled correctly.
   assign step_ge   = (work_q[64:32] >= {1'b0, divisor_q});
   assign step_diff = work_q[63:32] - divisor_q;

   assign quo_raw = work_q[31:0];
   assign rem_raw = work_q[64:33];
   assign quo_fix = (signed_q & (a_sign_q ^ b_sign_q)) ? (~quo_raw + 32'd1) : quo_raw;
   assign rem_fix = (signed_q & a_sign_q) ? (~rem_raw + 32'd1) : rem_raw;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      signed_d  = signed_q;
      a_sign_d  = a_sign_q;
      b_sign_d  = b_sign_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         S_IDLE: begin
            ready_d  = 1'b0;
            result_d = 64'd0;
            if (start_i && !annul_i) begin
               signed_d  = signed_div_i;
               a_sign_d  = opdata1_i[31];
               b_sign_d  = opdata2_i[31];
               divisor_d = abs_divisor;
               work_d    = {32'd0, abs_dividend, 1'b0};
               cnt_d     = 6'd0;
               if (opdata2_i == 32'd0) begin
                  state_d = S_BYZERO;
`ifdef DIV_EARLY_OUT_EN
               end else if (abs_dividend < abs_divisor) begin
                  state_d  = S_END;
                  result_d = {opdata1_i, 32'd0};
                  ready_d  = 1'b1;
`endif
               end else begin
                  state_d = S_ON;
               end
            end
         end

         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_END;
            end
            result_d = 64'd0;
            ready_d  = !annul_i;
         end

         S_ON: begin
            if (annul_i) begin
               state_d  = S_IDLE;
               cnt_d    = 6'd0;
               result_d = 64'd0;
               ready_d  = 1'b0;
            end else if (cnt_q == C_LAST_ITER) begin
               state_d  = S_END;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end else begin
               if (step_ge) begin
                  work_d = {step_diff, work_q[31:0], 1'b1};
               end else begin
                  work_d = {work_q[63:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
            end
         end

         S_END: begin
            if (annul_i || !start_i) begin
               state_d  = S_IDLE;
               cnt_d    = 6'd0;
               result_d = 64'd0;
               ready_d  = 1'b0;
            end
         end

         default: begin
            state_d  = S_IDLE;
            cnt_d    = 6'd0;
            result_d = 64'd0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         work_q    <= 65'd0;
         divisor_q <= 32'd0;
         signed_q  <= 1'b0;
         a_sign_q  <= 1'b0;
         b_sign_q  <= 1'b0;
         result_q  <= 64'd0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         signed_q  <= signed_d;
         a_sign_q  <= a_sign_d;
         b_sign_q  <= b_sign_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

`default_nettype wire

// File: doc/ex_div_ctrl.md
EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start_i, input, 1 bit: divide request from EX, held high until ready_o is seen.
REQ-004 SHALL have port annul_i, input, 1 bit: cancel the current operation (flush or branch-slot kill).
REQ-005 SHALL have port signed_div_i, input, 1 bit: 1 = DIV (signed), 0 = DIVU.
REQ-006 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-007 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-008 SHALL have port result_o, output, 64 bits: [63:32] remainder (HI) and [31:0] quotient (LO).
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-010 SHALL have port stallreq_o, output, 1 bit: pipeline stall request.

Function
REQ-011 SHALL implement states IDLE, BYZERO, ON and END, encoded in 2 bits, with a 6-bit iteration counter cnt.
REQ-012 In IDLE, when start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div_i; operand changes after that edge SHALL be ignored.
REQ-013 From IDLE, if the divisor is 0 the next state SHALL be BYZERO; otherwise the next state SHALL be ON with cnt=0.
REQ-014 For a signed operation, the block SHALL latch the operand magnitudes (two's-complement negation of negative values; 0x80000000 maps to unsigned 2^31).
REQ-015 In ON, the block SHALL perform one restoring shift-subtract step per clock on a 65-bit working register and increment cnt.
REQ-016 When cnt=32 in ON, the block SHALL load result_o, set ready_o=1 and go to END.
REQ-017 ready_o SHALL rise 33 clock edges after the edge that sampled start_i.
REQ-018 Signed result rules:
- the quotient SHALL be negated when the operand signs differ;
- the remainder SHALL take the sign of the dividend;
- all arithmetic SHALL be modulo 2^32, so overflow wraps with no flag.
REQ-019 BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1 (latency 2 edges).
REQ-020 In END, ready_o and result_o SHALL hold while start_i=1.
REQ-021 In END with start_i=0, the block SHALL return to IDLE with ready_o=0 and result_o=0.
REQ-022 A new start SHALL be accepted only from IDLE (no back-to-back start from END).
REQ-023 annul_i=1 in ON, BYZERO or END SHALL force IDLE on the next edge with ready_o=0 and result_o=0; no result SHALL be delivered.
REQ-024 annul_i=1 in IDLE SHALL block acceptance of start_i, including when start_i=1 on the same edge.
REQ-025 stallreq_o SHALL be combinational, equal to start_i AND NOT ready_o AND NOT annul_i.
REQ-026 The block SHALL drive no X on any output in any state; unused state encodings SHALL go to IDLE on the next edge.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, cnt=0, ready_o=0, result_o=0 and clear all latched operands, including in the middle of an operation.
REQ-028 rst SHALL take priority over annul_i and start_i.
REQ-029 stallreq_o SHALL follow REQ-025 during reset, since it depends only on inputs and ready_o.

Configuration
REQ-030 With macro DIV_EARLY_OUT_EN defined, an accepted request with a nonzero divisor whose |dividend| < |divisor| SHALL go from IDLE directly to END, with quotient 0, remainder equal to the dividend (original sign) and ready_o=1 after the sampling edge (latency 1).
REQ-031 With DIV_EARLY_OUT_EN undefined, such requests SHALL take the full 33-edge ON path with identical result values.

Verification
REQ-032 DIVU 100/7, start held -> ready_o rises 33 edges after start, result_o = {0x00000002, 0x0000000E}, stallreq_o=1 until ready_o.
REQ-033 DIV -7/2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-034 DIVU 5/0 -> ready_o after 2 edges, result_o = 0; then start_i low -> IDLE, ready_o=0 next edge.
REQ-035 Start 100/7, annul_i=1 at iteration 10 -> IDLE next edge, ready_o never asserts; a new 9/3 request then yields {0, 3} at 33 edges.
REQ-036 rst pulsed at iteration 20 -> all outputs 0 next edge; rst high with start_i high -> no acceptance.
REQ-037 DIVU 5/9 -> with DIV_EARLY_OUT_EN defined, ready_o after 1 edge with {0x00000005, 0x00000000}; without it, the same result after 33 edges.
